// File: rtl/alu_mul_seq_if.sv
// Bus between the multiply sequencer and its environment: request/result handshake
// plus the borrowed alu operand/opcode lines and the alu's same-cycle response.
interface alu_mul_seq_if;
    logic        start;
    logic [15:0] opnd_a;
    logic [15:0] opnd_b;
    logic        ready;
    logic        done;
    logic [15:0] product;
    logic        ovf;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [3:0]  alu_Op;
    logic [15:0] alu_Out;
    logic        alu_Cout;

    modport master (
        input  start, opnd_a, opnd_b, alu_Out, alu_Cout,
        output ready, done, product, ovf, alu_A, alu_B, alu_Op
    );

    modport slave (
        output start, opnd_a, opnd_b, alu_Out, alu_Cout,
        input  ready, done, product, ovf, alu_A, alu_B, alu_Op
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned 16x16->16 shift-and-add multiplier that owns no arithmetic:
// every add or shift is issued to an external alu and its result captured back.
module alu_mul_seq #(
    parameter logic [3:0] OP_ADD = 4'b0000,
    parameter logic [3:0] OP_SLL = 4'b0100
) (
    input  logic                clk,
    input  logic                rst,
    alu_mul_seq_if.master       bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_SHL  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic        ovf_q, ovf_d;

    logic [15:0] aluA, aluB;
    logic [3:0]  aluOp;
    logic [15:0] mplierShr;

    assign mplierShr = mplier_q >> 1;

    // Multiplier bits are consumed LSB first; a set bit costs an ADD before its SHL.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        ovf_d    = ovf_q;
        aluA     = 16'd0;
        aluB     = 16'd0;
        aluOp    = OP_ADD;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d    = 16'd0;
                    mcand_d  = bus.opnd_a;
                    mplier_d = bus.opnd_b;
                    ovf_d    = 1'b0;
                    if (bus.opnd_b == 16'd0) begin
                        state_d = S_FIN;
                    end else if (bus.opnd_b[0]) begin
                        state_d = S_ADD;
                    end else begin
                        state_d = S_SHL;
                    end
                end
            end

            S_ADD: begin
                aluA    = acc_q;
                aluB    = mcand_q;
                acc_d   = bus.alu_Out;
                ovf_d   = ovf_q | bus.alu_Cout;
                state_d = S_SHL;
            end

            S_SHL: begin
                aluOp    = OP_SLL;
                aluA     = mcand_q;
                aluB     = 16'd1;
                mcand_d  = bus.alu_Out;
                mplier_d = mplierShr;
                // A bit shifted out of the multiplicand still has a multiplier bit left to meet.
                if (mcand_q[15] && (mplierShr != 16'd0)) begin
                    ovf_d = 1'b1;
                end
                if (mplierShr == 16'd0) begin
                    state_d = S_FIN;
                end else if (mplier_q[1]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHL;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= 16'd0;
            mcand_q  <= 16'd0;
            mplier_q <= 16'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ready   = (state_q == S_IDLE);
    assign bus.done    = (state_q == S_FIN);
    assign bus.product = acc_q;
    assign bus.ovf     = ovf_q;
    assign bus.alu_A   = aluA;
    assign bus.alu_B   = aluB;
    assign bus.alu_Op  = aluOp;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomised scoreboard bench for alu_mul_seq with a behavioural external alu;
// expected results come from plain integer multiplication and bit counting.
module tb_alu_mul_seq;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b0100;

    typedef struct {
        logic [15:0] prod;
        logic        ovf;
        int          lat;
        int          adds;
        int          shls;
        int          startCyc;
    } expEntry_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    expEntry_t sbQ[$];

    alu_mul_seq_if bus ();

    alu_mul_seq #(
        .OP_ADD (OP_ADD),
        .OP_SLL (OP_SLL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // External alu: combinational add with carry, or shift-left by B.
    always_comb begin
        bus.alu_Out  = 16'd0;
        bus.alu_Cout = 1'b0;
        if (bus.alu_Op == OP_ADD) begin
            {bus.alu_Cout, bus.alu_Out} = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
        end else if (bus.alu_Op == OP_SLL) begin
            bus.alu_Out = bus.alu_A << bus.alu_B[3:0];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    function automatic expEntry_t refModel(input logic [15:0] a, input logic [15:0] b, input int startCyc);
        expEntry_t e;
        longint    p;
        int        msb;
        p   = longint'(a) * longint'(b);
        msb = -1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) msb = i;
        end
        e.prod     = p[15:0];
        e.ovf      = (p >= 65536);
        e.adds     = $countones(b);
        e.shls     = msb + 1;
        e.lat      = 1 + e.adds + e.shls;
        e.startCyc = startCyc;
        return e;
    endfunction

    // Waits (bounded) for ready, then presents one request for a single cycle.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        int guard;
        guard = 0;
        while (!bus.ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) checkOutput("ready_timeout", 32'(bus.ready), 32'd1);
        bus.start  = 1'b1;
        bus.opnd_a = a;
        bus.opnd_b = b;
        sbQ.push_back(refModel(a, b, cyc));
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Hammers start with junk operands for as long as the sequencer is busy.
    task automatic spamWhileBusy();
        int guard;
        guard = 0;
        while (!bus.ready && guard < 100) begin
            bus.start  = 1'b1;
            bus.opnd_a = 16'($urandom);
            bus.opnd_b = 16'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        bus.start = 1'b0;
        if (guard >= 100) checkOutput("busy_timeout", 32'(bus.ready), 32'd1);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (!bus.ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) checkOutput("idle_timeout", 32'(bus.ready), 32'd1);
    endtask

    // Monitor: counts issued alu ops, scores each done pulse, and checks idle hold behaviour.
    initial begin
        int          addCnt;
        int          shlCnt;
        logic [15:0] lastProd;
        logic        lastOvf;
        expEntry_t   e;
        addCnt   = 0;
        shlCnt   = 0;
        lastProd = 16'd0;
        lastOvf  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbQ.delete();
                addCnt   = 0;
                shlCnt   = 0;
                lastProd = 16'd0;
                lastOvf  = 1'b0;
            end else if (bus.done) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("product", 32'(bus.product), 32'(e.prod));
                    checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
                    checkOutput("latency", 32'(cyc - e.startCyc), 32'(e.lat));
                    checkOutput("add_count", 32'(addCnt), 32'(e.adds));
                    checkOutput("shl_count", 32'(shlCnt), 32'(e.shls));
                    checkOutput("done_ready", 32'(bus.ready), 32'd0);
                    lastProd = e.prod;
                    lastOvf  = e.ovf;
                end
                addCnt = 0;
                shlCnt = 0;
            end else if (bus.ready) begin
                checkOutput("idle_alu", {12'd0, bus.alu_Op, bus.alu_A}, {12'd0, OP_ADD, 16'd0});
                checkOutput("idle_aluB", 32'(bus.alu_B), 32'd0);
                checkOutput("held_result", {15'd0, bus.ovf, bus.product}, {15'd0, lastOvf, lastProd});
            end else begin
                if (bus.alu_Op == OP_ADD) addCnt++;
                else if (bus.alu_Op == OP_SLL) shlCnt++;
                else checkOutput("busy_op", 32'(bus.alu_Op), 32'(OP_SLL));
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int          guard;
        total      = 0;
        bad        = 0;
        cyc        = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.opnd_a = 16'd0;
        bus.opnd_b = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_ready", 32'(bus.ready), 32'd1);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_product", 32'(bus.product), 32'd0);
        checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);

        // Directed corner operands.
        applyStimulus(16'd3, 16'd5);            waitIdle();
        applyStimulus(16'h1234, 16'd0);         waitIdle();
        applyStimulus(16'hFFFF, 16'd2);         waitIdle();
        applyStimulus(16'h8001, 16'h8001);      waitIdle();
        applyStimulus(16'hFFFF, 16'hFFFF);      waitIdle();
        applyStimulus(16'h00FF, 16'h0100);      waitIdle();
        applyStimulus(16'h0001, 16'h8000);      waitIdle();

        // Back-to-back requests with start held high through every busy period.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(16'($urandom), 16'($urandom));
            spamWhileBusy();
        end

        // Randomised operands with a mix of operand widths.
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = 16'($urandom); b = 16'($urandom); end
                1: begin a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255)); end
                2: begin a = 16'($urandom); b = 16'd1 << $urandom_range(0, 15); end
                default: begin a = 16'($urandom); b = 16'($urandom_range(0, 15)); end
            endcase
            applyStimulus(a, b);
            if ($urandom_range(0, 1) == 1) spamWhileBusy();
        end
        waitIdle();

        // Reset in the middle of a shift: result discarded, no done pulse.
        applyStimulus(16'hABCD, 16'hFFFF);
        guard = 0;
        while (!(bus.alu_Op == OP_SLL && !bus.ready) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("reach_shl", 32'(guard < 50), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_ready", 32'(bus.ready), 32'd1);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkOutput("midrst_product", 32'(bus.product), 32'd0);
        checkOutput("midrst_ovf", 32'(bus.ovf), 32'd0);
        repeat (5) @(posedge clk);
        #1;

        applyStimulus(16'd7, 16'd9);
        waitIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(sbQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
